compare_lane_sequencer: RTL and testbench

//   Sequences a warp-wide set/compare (slt/sgt) through UNITS shared subtract+compare units.

---
 rtl/compare_lane_sequencer_if.sv | 26 ++
 rtl/compare_lane_sequencer.sv | 111 +++++++++++
 tb/tb_compare_lane_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/compare_lane_sequencer_if.sv
// Request/response bundle between the issue stage and the lane compare sequencer.
// The issue side uses the master modport and the sequencer uses the slave modport.
interface compare_lane_sequencer_if #(
  parameter int LANES     = 32,
  parameter int SRC_WIDTH = 32
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_slt;
  logic [LANES-1:0]           req_mask;
  logic [LANES*SRC_WIDTH-1:0] req_src_a;
  logic [LANES*SRC_WIDTH-1:0] req_src_b;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [LANES-1:0]           resp_pred;

  modport master (
    output req_valid, req_slt, req_mask, req_src_a, req_src_b, resp_ready,
    input  req_ready, resp_valid, resp_pred
  );

  modport slave (
    input  req_valid, req_slt, req_mask, req_src_a, req_src_b, resp_ready,
    output req_ready, resp_valid, resp_pred
  );
endinterface

// File: rtl/compare_lane_sequencer.sv
// Runs a warp-wide slt/sgt through UNITS shared compare units, one lane group per cycle,
// skipping groups whose mask slice is empty, and returns a registered predicate mask.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// RUN   | evaluating the group selected by grp, one active group per edge
// DONE  | resp_valid high, resp_pred held until resp_ready
module compare_lane_sequencer #(
  parameter int LANES     = 32,
  parameter int SRC_WIDTH = 32,
  parameter int UNITS     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  compare_lane_sequencer_if.slave  bus,
  output logic                     busy
);
  localparam int GROUPS = LANES / UNITS;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state;
  logic [GW-1:0]              grp;
  logic                       slt_q;
  logic [LANES-1:0]           mask_q;
  logic [LANES*SRC_WIDTH-1:0] src_a_q;
  logic [LANES*SRC_WIDTH-1:0] src_b_q;
  logic [LANES-1:0]           resp_pred_q;

  int                         grp_base;
  logic [GW-1:0]              first_grp;
  logic                       first_found;
  logic [GW-1:0]              next_grp;
  logic                       next_found;
  logic [UNITS-1:0]           grp_pred;
  logic [SRC_WIDTH-1:0]       a_l;
  logic [SRC_WIDTH-1:0]       b_l;
  logic [SRC_WIDTH-1:0]       d_l;

  assign grp_base = int'(grp) * UNITS;

  // Scan downwards so the lowest qualifying group is the one that sticks.
  always_comb begin
    first_grp   = '0;
    first_found = 1'b0;
    next_grp    = '0;
    next_found  = 1'b0;
    for (int g = GROUPS - 1; g >= 0; g--) begin
      if (|bus.req_mask[g*UNITS +: UNITS]) begin
        first_grp   = GW'(g);
        first_found = 1'b1;
      end
      if ((g > int'(grp)) && (|mask_q[g*UNITS +: UNITS])) begin
        next_grp   = GW'(g);
        next_found = 1'b1;
      end
    end
  end

  // Wrapping subtract with no overflow correction: the sign of d alone decides.
  always_comb begin
    grp_pred = '0;
    a_l      = '0;
    b_l      = '0;
    d_l      = '0;
    for (int u = 0; u < UNITS; u++) begin
      a_l         = src_a_q[(grp_base + u)*SRC_WIDTH +: SRC_WIDTH];
      b_l         = src_b_q[(grp_base + u)*SRC_WIDTH +: SRC_WIDTH];
      d_l         = a_l - b_l;
      grp_pred[u] = (slt_q ? d_l[SRC_WIDTH-1] : (~d_l[SRC_WIDTH-1] & (|d_l)))
                    & mask_q[grp_base + u];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      resp_pred_q <= '0;
      grp         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            slt_q       <= bus.req_slt;
            mask_q      <= bus.req_mask;
            src_a_q     <= bus.req_src_a;
            src_b_q     <= bus.req_src_b;
            resp_pred_q <= '0;
            grp         <= first_grp;
            state       <= first_found ? RUN : DONE;
          end
        end
        RUN: begin
          resp_pred_q[grp_base +: UNITS] <= grp_pred;
          if (next_found) grp <= next_grp;
          else            state <= DONE;
        end
        DONE: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE) & rst_n;
  assign bus.resp_valid = (state == DONE) & rst_n;
  assign bus.resp_pred  = resp_pred_q;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_compare_lane_sequencer.sv
// Directed bench for compare_lane_sequencer at LANES=32, SRC_WIDTH=32, UNITS=8.
// Expected predicates and latencies are hand-computed constants.
module tb_compare_lane_sequencer;
  localparam int LANES = 32;
  localparam int SW    = 32;
  localparam int VW    = LANES * SW;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_checks;
  int   n_errors;

  compare_lane_sequencer_if #(.LANES(LANES), .SRC_WIDTH(SW)) bus ();

  compare_lane_sequencer #(.LANES(LANES), .SRC_WIDTH(SW), .UNITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [SW-1:0] v);
    return {LANES{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure edges from accept to resp_valid, check result, then drain.
  task automatic send(input string tag, input logic slt, input logic [LANES-1:0] mask,
                      input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input int exp_lat, input logic [LANES-1:0] exp_pred);
    int lat;
    bus.req_valid = 1'b1;
    bus.req_slt   = slt;
    bus.req_mask  = mask;
    bus.req_src_a = a;
    bus.req_src_b = b;
    check({tag, " ready"}, 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " pred"}, 64'(bus.resp_pred), 64'(exp_pred));
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, " drained"}, 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    int            lat;
    int            stray;
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_slt    = 1'b0;
    bus.req_mask   = '0;
    bus.req_src_a  = '0;
    bus.req_src_b  = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    check("rst req_ready", 64'(bus.req_ready), 64'd0);
    check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst resp_pred", 64'(bus.resp_pred), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;

    // Basic sgt/slt, full mask, worst-case latency
    send("t1 sgt", 1'b0, 32'hFFFF_FFFF, fill(32'd5), fill(32'd3), 4, 32'hFFFF_FFFF);
    send("t1 slt", 1'b1, 32'hFFFF_FFFF, fill(32'd5), fill(32'd3), 4, 32'h0000_0000);

    // Equal operands never set
    send("t2 eq sgt", 1'b0, 32'hFFFF_FFFF, fill(32'd7), fill(32'd7), 4, 32'h0);
    send("t2 eq slt", 1'b1, 32'hFFFF_FFFF, fill(32'd7), fill(32'd7), 4, 32'h0);
    a = fill(32'd7);
    b = fill(32'd7);
    a[0 +: SW] = 32'd2;
    b[0 +: SW] = 32'd9;
    send("t2 lane0", 1'b1, 32'hFFFF_FFFF, a, b, 4, 32'h0000_0001);

    // Wrapping difference: only the raw sign bit counts
    a = '0;
    b = '0;
    a[0 +: SW]  = 32'h8000_0000;
    b[0 +: SW]  = 32'h0000_0001;
    a[SW +: SW] = 32'h0000_0000;
    b[SW +: SW] = 32'h0000_0001;
    send("t3 wrap", 1'b1, 32'hFFFF_FFFF, a, b, 4, 32'h0000_0002);

    // Sparse masks and group skipping
    send("t4 m00FF0000", 1'b0, 32'h00FF_0000, fill(32'd1), fill(32'd0), 1, 32'h00FF_0000);
    send("t4 m80000001", 1'b0, 32'h8000_0001, fill(32'd1), fill(32'd0), 2, 32'h8000_0001);
    send("t4 m0", 1'b0, 32'h0000_0000, fill(32'd1), fill(32'd0), 0, 32'h0000_0000);

    // Backpressure while a new request waits outside IDLE
    bus.req_valid = 1'b1;
    bus.req_slt   = 1'b0;
    bus.req_mask  = 32'hFFFF_FFFF;
    bus.req_src_a = fill(32'd5);
    bus.req_src_b = fill(32'd3);
    tick();
    bus.req_slt   = 1'b1;
    bus.req_mask  = 32'h0000_FFFF;
    bus.req_src_a = fill(32'd3);
    bus.req_src_b = fill(32'd5);
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("t5 latency", 64'(lat), 64'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5 hold valid", 64'(bus.resp_valid), 64'd1);
      check("t5 hold pred", 64'(bus.resp_pred), 64'hFFFF_FFFF);
      check("t5 hold ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("t5 release valid", 64'(bus.resp_valid), 64'd0);
    check("t5 release busy", 64'(busy), 64'd0);
    check("t5 release ready", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    check("t5 next accepted", 64'(busy), 64'd1);
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("t5 next latency", 64'(lat), 64'd2);
    check("t5 next pred", 64'(bus.resp_pred), 64'h0000_FFFF);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;

    // Reset on the second RUN cycle aborts the operation
    bus.req_valid = 1'b1;
    bus.req_slt   = 1'b0;
    bus.req_mask  = 32'hFFFF_FFFF;
    bus.req_src_a = fill(32'd5);
    bus.req_src_b = fill(32'd3);
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("t6 rst busy", 64'(busy), 64'd0);
    check("t6 rst valid", 64'(bus.resp_valid), 64'd0);
    check("t6 rst pred", 64'(bus.resp_pred), 64'd0);
    check("t6 rst ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.resp_valid) stray++;
    end
    check("t6 no response", 64'(stray), 64'd0);
    send("t6 fresh", 1'b1, 32'hFFFF_FFFF, fill(32'd2), fill(32'd9), 4, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
